// File: rtl/pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder
//
// Purpose:
//   Pipelined ripple-carry adder. A WIDTH-bit addition is cut into SEG-bit
//   ripple segments, with one segment resolved per pipeline stage. The carry
//   between segments travels in registers. The operands are first captured in
//   an input register rank. They then pass through STAGES compute ranks. The
//   last rank drives the outputs, so the latency is STAGES cycles from
//   acceptance to out_valid.
//
//   Flow control is a single global stall: every rank advances together when
//   the output rank is empty or is being consumed. Bubbles are not collapsed.
//
// Build option:
//   APPROX_LSB_EN - when defined, the lowest APPROX_BITS sum bits are a | b.
//                   cin is ignored. The carry into bit APPROX_BITS is
//                   a[APPROX_BITS-1] & b[APPROX_BITS-1]. All bits above are
//                   exact. When undefined, every bit is exact and
//                   APPROX_BITS only takes part in the parameter range check.
//
// Parameters:
//   WIDTH       operand/sum width; must be a multiple of SEG
//   SEG         bits resolved per stage (STAGES = WIDTH / SEG)
//   APPROX_BITS approximated LSB count, 0..WIDTH-SEG
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset, priority over handshakes
//   in_valid   operands present
//   in_ready   operands accepted this cycle (equals the global advance)
//   a, b, cin  operands and carry into bit 0
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module pipelined_rca_adder #(
  parameter int WIDTH       = 16,
  parameter int SEG         = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

`ifdef APPROX_LSB_EN
  localparam logic [WIDTH-1:0] APPROX_MASK = (WIDTH'(1) << APPROX_BITS) - WIDTH'(1);
`else
  localparam logic [WIDTH-1:0] APPROX_MASK = '0;
`endif

  // ---------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // ---------------------------------------------------------------------------
  if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("pipelined_rca_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  if ((APPROX_BITS < 0) || (APPROX_BITS > (WIDTH - SEG))) begin : g_bad_approx
    $error("pipelined_rca_adder: APPROX_BITS (%0d) must lie in 0..WIDTH-SEG", APPROX_BITS);
  end

  // ---------------------------------------------------------------------------
  // Input conditioning
  //
  // In approximate mode, the approximated low bits of the operands are
  // rewritten so that the ordinary ripple chain produces the required carry
  // into bit APPROX_BITS. The low bits of a become {APPROX_BITS{low_carry}}
  // and the low bits of b become 1, with the carry-in forced to 0. The low
  // bits then sum to all-ones + 1, which carries exactly when low_carry is 1.
  // The garbage sum bits this produces are masked off. The (a | b) value is
  // carried along in the partial-sum register instead.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] lo_in;
  logic             c_in;

`ifdef APPROX_LSB_EN
  if (APPROX_BITS > 0) begin : g_approx_in
    logic low_carry;
    assign low_carry = a[APPROX_BITS-1] & b[APPROX_BITS-1];
    assign a_in      = (a & ~APPROX_MASK) | (low_carry ? APPROX_MASK : '0);
    assign b_in      = (b & ~APPROX_MASK) | WIDTH'(1);
    assign c_in      = 1'b0;
    assign lo_in     = (a | b) & APPROX_MASK;
  end else begin : g_exact_in
    assign a_in  = a;
    assign b_in  = b;
    assign c_in  = cin;
    assign lo_in = '0;
  end
`else
  assign a_in  = a;
  assign b_in  = b;
  assign c_in  = cin;
  assign lo_in = '0;
`endif

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic              advance;

  // Input capture rank (the "delayed operands" seen by stage 0)
  logic              cap_valid_reg;
  logic [WIDTH-1:0]  cap_a_reg;
  logic [WIDTH-1:0]  cap_b_reg;
  logic [WIDTH-1:0]  cap_lo_reg;
  logic              cap_carry_reg;

  // Stage output ranks: stage k has resolved sum bits [0 .. (k+1)*SEG-1]
  logic [STAGES-1:0] st_valid_reg;
  logic [STAGES-1:0] st_carry_reg;
  logic [WIDTH-1:0]  st_a_reg   [STAGES];
  logic [WIDTH-1:0]  st_b_reg   [STAGES];
  logic [WIDTH-1:0]  st_sum_reg [STAGES];
  logic              ovf_reg;

  logic [STAGES-1:0] st_valid_next;
  logic [STAGES-1:0] st_carry_next;
  logic [WIDTH-1:0]  st_a_next   [STAGES];
  logic [WIDTH-1:0]  st_b_next   [STAGES];
  logic [WIDTH-1:0]  st_sum_next [STAGES];
  logic              ovf_next;

  // ---------------------------------------------------------------------------
  // Per-stage segment adders
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LSB = gi * SEG;
    localparam logic [WIDTH-1:0] SEG_MASK   = WIDTH'({SEG{1'b1}}) << LSB;
    // Approximated bits are never overwritten by the ripple result.
    localparam logic [WIDTH-1:0] WRITE_MASK = SEG_MASK & ~APPROX_MASK;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] lower;
    logic             carry_in;
    logic             valid_in;
    logic [SEG:0]     seg_sum;

    if (gi == 0) begin : g_head
      assign op_a     = cap_a_reg;
      assign op_b     = cap_b_reg;
      assign lower    = cap_lo_reg;
      assign carry_in = cap_carry_reg;
      assign valid_in = cap_valid_reg;
    end else begin : g_body
      assign op_a     = st_a_reg[gi-1];
      assign op_b     = st_b_reg[gi-1];
      assign lower    = st_sum_reg[gi-1];
      assign carry_in = st_carry_reg[gi-1];
      assign valid_in = st_valid_reg[gi-1];
    end

    assign seg_sum = {1'b0, op_a[LSB +: SEG]}
                   + {1'b0, op_b[LSB +: SEG]}
                   + {{SEG{1'b0}}, carry_in};

    assign st_sum_next[gi]   = (lower & ~WRITE_MASK)
                             | ((WIDTH'(seg_sum[SEG-1:0]) << LSB) & WRITE_MASK);
    assign st_carry_next[gi] = seg_sum[SEG];
    assign st_a_next[gi]     = op_a;
    assign st_b_next[gi]     = op_b;
    assign st_valid_next[gi] = valid_in;
  end

  // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
  // The MSB is always exact because APPROX_BITS <= WIDTH-SEG.
  assign ovf_next = st_a_next[LAST][WIDTH-1]
                  ^ st_b_next[LAST][WIDTH-1]
                  ^ st_sum_next[LAST][WIDTH-1]
                  ^ st_carry_next[LAST];

  // ---------------------------------------------------------------------------
  // Global stall
  // ---------------------------------------------------------------------------
  assign advance  = !st_valid_reg[LAST] || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_reg <= 1'b0;
      cap_a_reg     <= '0;
      cap_b_reg     <= '0;
      cap_lo_reg    <= '0;
      cap_carry_reg <= 1'b0;
      st_valid_reg  <= '0;
      st_carry_reg  <= '0;
      ovf_reg       <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_a_reg[k]   <= '0;
        st_b_reg[k]   <= '0;
        st_sum_reg[k] <= '0;
      end
    end else if (advance) begin
      cap_valid_reg <= in_valid;
      cap_a_reg     <= a_in;
      cap_b_reg     <= b_in;
      cap_lo_reg    <= lo_in;
      cap_carry_reg <= c_in;
      st_valid_reg  <= st_valid_next;
      st_carry_reg  <= st_carry_next;
      ovf_reg       <= ovf_next;
      for (int k = 0; k < STAGES; k++) begin
        st_a_reg[k]   <= st_a_next[k];
        st_b_reg[k]   <= st_b_next[k];
        st_sum_reg[k] <= st_sum_next[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the last rank, so they hold during a stall.
  // ---------------------------------------------------------------------------
  assign out_valid = st_valid_reg[LAST];
  assign sum       = st_sum_reg[LAST];
  assign cout      = st_carry_reg[LAST];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_rca_adder
//
// Directed self-checking bench for pipelined_rca_adder with WIDTH=16, SEG=4.
// All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipelined_rca_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_rca_adder #(
    .WIDTH       (16),
    .SEG         (4),
    .APPROX_BITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Drives one transaction into an empty pipeline. It returns the number of
  // edges from acceptance to out_valid (-1 if none) and the observed result.
  task automatic send_one(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          output int lat, output logic [15:0] s,
                          output logic co, output logic ov);
    lat = -1;
    s   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (out_valid === 1'b1) begin
        lat = i; s = sum; co = cout; ov = ovf;
        break;
      end
    end
    $display("txn a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b latency=%0d", ta, tb, tc, s, co, ov, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if ({cout, ovf, sum} !== 18'h0) begin
      n_bad++; $display("FAIL reset_outputs: got cout=%b ovf=%b sum=%h expected all 0", cout, ovf, sum);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_arith();
    logic [15:0] va [5];
    logic [15:0] vb [5];
    logic        vc [5];
    logic [17:0] ve [5];   // {cout, ovf, sum}
    int          lat;
    logic [15:0] s;
    logic        co, ov;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; ve[0] = {1'b1, 1'b0, 16'h0000};
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0; ve[1] = {1'b0, 1'b1, 16'h8000};
    va[2] = 16'h1234; vb[2] = 16'h4321; vc[2] = 1'b1; ve[2] = {1'b0, 1'b0, 16'h5556};
    va[3] = 16'h8000; vb[3] = 16'h8000; vc[3] = 1'b0; ve[3] = {1'b1, 1'b1, 16'h0000};
    va[4] = 16'hFFFF; vb[4] = 16'hFFFF; vc[4] = 1'b1; ve[4] = {1'b1, 1'b0, 16'hFFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_one(va[i], vb[i], vc[i], lat, s, co, ov);
      n_cmp++;
      if (lat !== 4) begin
        n_bad++; $display("FAIL arith_latency[%0d]: got %0d expected 4", i, lat);
      end
      n_cmp++;
      if ({co, ov, s} !== ve[i]) begin
        n_bad++; $display("FAIL arith_result[%0d]: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                          i, co, ov, s, ve[i][17], ve[i][16], ve[i][15:0]);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL arith_no_duplicate[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic [17:0] ve [6];
    int          seen;
    int          first;
    va[0] = 16'h0001; vb[0] = 16'h0002; vc[0] = 1'b0; ve[0] = {1'b0, 1'b0, 16'h0003};
    va[1] = 16'hABCD; vb[1] = 16'h1111; vc[1] = 1'b1; ve[1] = {1'b0, 1'b0, 16'hBCDF};
    va[2] = 16'h8000; vb[2] = 16'hFFFF; vc[2] = 1'b0; ve[2] = {1'b1, 1'b1, 16'h7FFF};
    va[3] = 16'h0F0F; vb[3] = 16'hF0F0; vc[3] = 1'b1; ve[3] = {1'b1, 1'b0, 16'h0000};
    va[4] = 16'h5555; vb[4] = 16'h5555; vc[4] = 1'b0; ve[4] = {1'b0, 1'b1, 16'hAAAA};
    va[5] = 16'h00FF; vb[5] = 16'h0F01; vc[5] = 1'b0; ve[5] = {1'b0, 1'b0, 16'h1000};
    seen  = 0;
    first = -1;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          if (out_valid === 1'b1) begin
            $display("txn b2b[%0d] -> sum=%h cout=%b ovf=%b cycle=%0d", seen, sum, cout, ovf, c);
            if (seen < 6) begin
              n_cmp++;
              if ({cout, ovf, sum} !== ve[seen]) begin
                n_bad++; $display("FAIL b2b_result[%0d]: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                                  seen, cout, ovf, sum, ve[seen][17], ve[seen][16], ve[seen][15:0]);
              end
            end
            if (first < 0) begin
              first = c;
            end else begin
              n_cmp++;
              if (c !== first + seen) begin
                n_bad++; $display("FAIL b2b_consecutive[%0d]: got cycle %0d expected %0d", seen, c, first + seen);
              end
            end
            seen++;
          end
        end
      end
    join
    n_cmp++;
    if (seen !== 6) begin
      n_bad++; $display("FAIL b2b_count: got %0d results expected 6", seen);
    end
  endtask

  task automatic test_stall();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [17:0] ve [3];
    int          got;
    int          idx;
    va[0] = 16'h1000; vb[0] = 16'h0234; vc[0] = 1'b0; ve[0] = {1'b0, 1'b0, 16'h1234};
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b0; ve[1] = {1'b1, 1'b0, 16'hFFFE};
    va[2] = 16'h4000; vb[2] = 16'h4000; vc[2] = 1'b1; ve[2] = {1'b0, 1'b1, 16'h8001};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid === 1'b1) begin
        got = 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (got !== 1) begin
      n_bad++; $display("FAIL stall_first_arrival: got no result expected one within 10 cycles");
    end
    n_cmp++;
    if ({cout, ovf, sum} !== ve[0]) begin
      n_bad++; $display("FAIL stall_first_result: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                        cout, ovf, sum, ve[0][17], ve[0][16], ve[0][15:0]);
    end
    $display("txn stall[0] -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
    // Stall the consumer and offer a junk operand that must not be taken.
    out_ready = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready);
      end
      n_cmp++;
      if ({out_valid, cout, ovf, sum} !== {1'b1, ve[0]}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got valid=%b cout=%b ovf=%b sum=%h expected valid=1 cout=%b ovf=%b sum=%h",
                          c, out_valid, cout, ovf, sum, ve[0][17], ve[0][16], ve[0][15:0]);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    idx = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        $display("txn stall[%0d] -> sum=%h cout=%b ovf=%b", idx, sum, cout, ovf);
        if (idx < 3) begin
          n_cmp++;
          if ({cout, ovf, sum} !== ve[idx]) begin
            n_bad++; $display("FAIL stall_drain[%0d]: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                              idx, cout, ovf, sum, ve[idx][17], ve[idx][16], ve[idx][15:0]);
          end
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx !== 3) begin
      n_bad++; $display("FAIL stall_count: got %0d results expected 3", idx);
    end
  endtask

  task automatic test_reset_midflight();
    int          stale;
    int          lat;
    logic [15:0] s;
    logic        co, ov;
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h3333; b = 16'h4444; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
    end
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_bad++; $display("FAIL midreset_stale: got %0d stale results expected 0", stale);
    end
    send_one(16'h0F00, 16'h00F0, 1'b1, lat, s, co, ov);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL midreset_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({co, ov, s} !== {1'b0, 1'b0, 16'h0FF1}) begin
      n_bad++; $display("FAIL midreset_result: got cout=%b ovf=%b sum=%h expected cout=0 ovf=0 sum=0ff1", co, ov, s);
    end
  endtask

`ifdef APPROX_LSB_EN
  task automatic test_approx();
    int          lat;
    logic [15:0] s;
    logic        co, ov;
    out_ready = 1'b1;
    send_one(16'h000F, 16'h0001, 1'b1, lat, s, co, ov);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL approx_latency0: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({co, s} !== {1'b0, 16'h000F}) begin
      n_bad++; $display("FAIL approx_result0: got cout=%b sum=%h expected cout=0 sum=000f", co, s);
    end
    send_one(16'h0008, 16'h0008, 1'b0, lat, s, co, ov);
    n_cmp++;
    if ({co, s} !== {1'b0, 16'h0018}) begin
      n_bad++; $display("FAIL approx_result1: got cout=%b sum=%h expected cout=0 sum=0018", co, s);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    test_reset();
`ifdef APPROX_LSB_EN
    test_approx();
`else
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add into SEG-bit ripple-carry segments, one segment per pipeline stage; carry travels between stages in registers.
- Valid/ready handshakes on input and output.
- Used as the accumulation/partial-product adder in the approximate multiplier datapath.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG.
- APPROX_BITS, 4, number of LSBs computed approximately; used only when APPROX_LSB_EN is defined; range 0..WIDTH-SEG.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  adder accepts operands this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0. in_ready reads 1 in the cycle after reset.
- Stage k (0..STAGES-1):
  - Adds bits [k*SEG +: SEG] of the delayed operands plus the registered carry from stage k-1 (cin for stage 0).
  - Registers that segment result, its carry, and the not-yet-added upper operand bits.
  - Already-computed lower sum bits are forwarded unchanged.
- Latency: a transaction accepted on edge N (in_valid & in_ready) presents out_valid = 1 with its result after edge N+STAGES.
- Throughput: one transaction per cycle when out_ready stays high.
- Flow control is a global stall: advance = !out_valid | out_ready.
  - in_ready = advance.
  - When advance = 0, every stage register, including outputs, holds its value.
  - Bubbles are not collapsed.
- Output hold: sum, cout and ovf must stay stable while out_valid = 1 and out_ready = 0.
- Ordering: results are emitted strictly in acceptance order; no drops, no duplicates.
- Arithmetic: full WIDTH+1-bit result, where cout = bit WIDTH.
  - ovf is computed from the top segment: (carry into bit WIDTH-1) XOR cout.
  - ovf is meaningful only for signed interpretation.
- Boundary cases:
  - in_valid = 0 on an accepting cycle injects a bubble (valid 0); datapath contents are don't-care.
  - Output handshake and input acceptance in the same cycle are legal; both happen.
  - rst asserted mid-operation discards all in-flight transactions: out_valid = 0 after the reset edge, and nothing is emitted afterwards for pre-reset inputs.
  - rst has priority over all handshakes.
- Constraints: SEG = WIDTH gives a single-stage registered adder, latency 1. WIDTH not divisible by SEG is a configuration error; elaboration must fail via a generate-time check.

Optional Feature:
- Macro: APPROX_LSB_EN.
- When defined: the lowest APPROX_BITS sum bits are a | b (lower-part OR approximation); cin is ignored; carry into bit APPROX_BITS is a[APPROX_BITS-1] & b[APPROX_BITS-1]. Bits above are exact. Latency and handshake are unchanged.
- When undefined: all bits are exact; APPROX_BITS has no effect.

Test Plan:
- WIDTH=16, SEG=4: a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> sum=0x0000, cout=1, ovf=0; out_valid rises exactly 4 edges after acceptance.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Back-to-back 6 random transactions with out_ready=1 -> 6 results on 6 consecutive cycles, in order, each matching a+b+cin.
- Stall: 3 transactions, out_ready=0 from the cycle the first result appears, held 5 cycles.
  - Required: in_ready=0 during the stall, first result held stable.
  - On out_ready=1, all 3 results emerge in order with none lost.
- Reset mid-flight: rst=1 for one cycle while 2 transactions are in flight -> out_valid=0 after the reset edge, no stale result emitted, next input's result correct at latency 4.
- APPROX_LSB_EN defined, APPROX_BITS=4: a=0x000F, b=0x0001, cin=1 -> sum=0x000F, cout=0 (exact would be 0x0011). a=0x0008, b=0x0008 -> sum=0x0018.
